// File: rtl/dcache_pkg.sv
// Shared types and defaults for the data-cache access arbiter slice.
// Build option: DCACHE_ARB_PERF_EN enables the performance counters.
package dcache_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_WORD_W     = 32;
    localparam int DEF_BLOCK_SIZE = 128;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_LD   = 2'd1,
        REQ_ST   = 2'd2,
        REQ_FILL = 2'd3
    } req_type_t;

    typedef enum logic {
        IDLE      = 1'b0,
        MISS_WAIT = 1'b1
    } arb_state_t;

    // Saturating increment so a long-running counter never wraps back to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        logic [31:0] r;
        if (v == 32'hFFFF_FFFF) begin
            r = v;
        end else begin
            r = v + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dcache_access_arbiter_if.sv
// Bundle of requester, cache, MSHR and perf signals around the access arbiter.
// master = environment side (requesters, cache, MSHR); slave = arbiter side.
interface dcache_access_arbiter_if #(
    parameter int ADDR_W     = dcache_pkg::DEF_ADDR_W,
    parameter int WORD_W     = dcache_pkg::DEF_WORD_W,
    parameter int BLOCK_SIZE = dcache_pkg::DEF_BLOCK_SIZE
) ();

    logic                  ld_valid_i;
    logic                  ld_ready_o;
    logic [ADDR_W-1:0]     ld_addr_i;
    logic                  st_valid_i;
    logic                  st_ready_o;
    logic [ADDR_W-1:0]     st_addr_i;
    logic [WORD_W-1:0]     st_data_i;
    logic                  fill_valid_i;
    logic                  fill_ready_o;
    logic [ADDR_W-1:0]     fill_addr_i;
    logic [BLOCK_SIZE-1:0] fill_data_i;
    logic                  cache_r_en_o;
    logic [ADDR_W-1:0]     cache_r_addr_o;
    logic                  cache_w_en_o;
    logic [ADDR_W-1:0]     cache_w_addr_o;
    logic [WORD_W-1:0]     cache_w_data_o;
    logic                  cache_is_repair_o;
    logic [BLOCK_SIZE-1:0] cache_repair_data_o;
    logic [WORD_W-1:0]     cache_r_data_i;
    logic                  cache_r_hit_i;
    logic                  cache_w_hit_i;
    logic                  ld_resp_valid_o;
    logic                  ld_resp_hit_o;
    logic [WORD_W-1:0]     ld_resp_data_o;
    logic                  st_resp_valid_o;
    logic                  st_resp_hit_o;
    logic                  miss_valid_o;
    logic                  miss_ready_i;
    logic [ADDR_W-1:0]     miss_addr_o;
    logic                  miss_is_store_o;
    logic [31:0]           perf_ld_cnt_o;
    logic [31:0]           perf_st_cnt_o;
    logic [31:0]           perf_fill_cnt_o;
    logic [31:0]           perf_stall_cnt_o;

    modport slave (
        input  ld_valid_i, ld_addr_i, st_valid_i, st_addr_i, st_data_i,
        input  fill_valid_i, fill_addr_i, fill_data_i,
        input  cache_r_data_i, cache_r_hit_i, cache_w_hit_i, miss_ready_i,
        output ld_ready_o, st_ready_o, fill_ready_o,
        output cache_r_en_o, cache_r_addr_o, cache_w_en_o, cache_w_addr_o, cache_w_data_o,
        output cache_is_repair_o, cache_repair_data_o,
        output ld_resp_valid_o, ld_resp_hit_o, ld_resp_data_o, st_resp_valid_o, st_resp_hit_o,
        output miss_valid_o, miss_addr_o, miss_is_store_o,
        output perf_ld_cnt_o, perf_st_cnt_o, perf_fill_cnt_o, perf_stall_cnt_o
    );

    modport master (
        output ld_valid_i, ld_addr_i, st_valid_i, st_addr_i, st_data_i,
        output fill_valid_i, fill_addr_i, fill_data_i,
        output cache_r_data_i, cache_r_hit_i, cache_w_hit_i, miss_ready_i,
        input  ld_ready_o, st_ready_o, fill_ready_o,
        input  cache_r_en_o, cache_r_addr_o, cache_w_en_o, cache_w_addr_o, cache_w_data_o,
        input  cache_is_repair_o, cache_repair_data_o,
        input  ld_resp_valid_o, ld_resp_hit_o, ld_resp_data_o, st_resp_valid_o, st_resp_hit_o,
        input  miss_valid_o, miss_addr_o, miss_is_store_o,
        input  perf_ld_cnt_o, perf_st_cnt_o, perf_fill_cnt_o, perf_stall_cnt_o
    );

endinterface

// File: rtl/dcache_perf_ctrs.sv
// Saturating event counters for the access arbiter (granted loads, stores,
// fills, and cycles spent waiting on the MSHR). Only instantiated when
// DCACHE_ARB_PERF_EN is defined.
module dcache_perf_ctrs
    import dcache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_gnt,
    input  logic        st_gnt,
    input  logic        fill_gnt,
    input  logic        stall,
    output logic [31:0] ld_cnt,
    output logic [31:0] st_cnt,
    output logic [31:0] fill_cnt,
    output logic [31:0] stall_cnt
);

    logic [31:0] ld_cnt_r;
    logic [31:0] st_cnt_r;
    logic [31:0] fill_cnt_r;
    logic [31:0] stall_cnt_r;

    // Count each event once per cycle it occurs, holding at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt_r    <= 32'd0;
            st_cnt_r    <= 32'd0;
            fill_cnt_r  <= 32'd0;
            stall_cnt_r <= 32'd0;
        end else begin
            if (ld_gnt) begin
                ld_cnt_r <= sat_inc32(ld_cnt_r);
            end
            if (st_gnt) begin
                st_cnt_r <= sat_inc32(st_cnt_r);
            end
            if (fill_gnt) begin
                fill_cnt_r <= sat_inc32(fill_cnt_r);
            end
            if (stall) begin
                stall_cnt_r <= sat_inc32(stall_cnt_r);
            end
        end
    end

    assign ld_cnt    = ld_cnt_r;
    assign st_cnt    = st_cnt_r;
    assign fill_cnt  = fill_cnt_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: rtl/dcache_access_arbiter.sv
// Single-port data-cache access arbiter: shares the one cache slot between
// MSHR refills, loads and the store drain, returns responses one cycle after
// the grant and hands misses to the MSHR with a valid/ready handshake.
// Build option: DCACHE_ARB_PERF_EN adds saturating perf counters; otherwise
// the perf_*_o ports read as zero.
module dcache_access_arbiter
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int WORD_W     = DEF_WORD_W,
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int STARVE_MAX = 4
) (
    input logic                   clk,
    input logic                   rst,
    dcache_access_arbiter_if.slave bus
);

    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

    arb_state_t        state_r;
    arb_state_t        state_next_s;
    logic [3:0]        starve_cnt_r;
    logic [3:0]        starve_cnt_next_s;
    req_type_t         resp_type_r;
    req_type_t         resp_type_next_s;
    logic [ADDR_W-1:0] resp_addr_r;
    logic [ADDR_W-1:0] resp_addr_next_s;
    logic [ADDR_W-1:0] miss_addr_r;
    logic [ADDR_W-1:0] miss_addr_next_s;
    logic              miss_is_store_r;
    logic              miss_is_store_next_s;

    logic              resp_ld_s;
    logic              resp_st_s;
    logic              resp_miss_s;
    logic              acc_open_s;
    logic              store_turn_s;
    logic              ld_ready_s;
    logic              st_ready_s;
    logic              ld_gnt_s;
    logic              st_gnt_s;
    logic              fill_gnt_s;

    logic                  r_en_s;
    logic [ADDR_W-1:0]     r_addr_s;
    logic                  w_en_s;
    logic [ADDR_W-1:0]     w_addr_s;
    logic [WORD_W-1:0]     w_data_s;
    logic                  is_repair_s;
    logic [BLOCK_SIZE-1:0] repair_data_s;

    // Decode the response stage; a miss is visible in the same cycle the cache result returns.
    always_comb begin
        resp_ld_s   = (resp_type_r == REQ_LD);
        resp_st_s   = (resp_type_r == REQ_ST);
        resp_miss_s = (resp_ld_s && !bus.cache_r_hit_i) || (resp_st_s && !bus.cache_w_hit_i);
    end

    // Grant selection: fill first, then load unless the store has starved long enough.
    // Load/store ready also drops in the miss-detect cycle so nothing is in flight behind a miss.
    always_comb begin
        fill_gnt_s   = bus.fill_valid_i;
        acc_open_s   = (state_r == IDLE) && !resp_miss_s && !bus.fill_valid_i;
        store_turn_s = (starve_cnt_r == STARVE_MAX_C) && bus.st_valid_i;
        ld_ready_s   = acc_open_s && !store_turn_s;
        st_ready_s   = acc_open_s && (store_turn_s || !bus.ld_valid_i);
        ld_gnt_s     = bus.ld_valid_i && ld_ready_s;
        st_gnt_s     = bus.st_valid_i && st_ready_s;
    end

    // Drive the cache ports from whichever requester won this cycle; idle ports read zero.
    always_comb begin
        r_en_s        = 1'b0;
        r_addr_s      = {ADDR_W{1'b0}};
        w_en_s        = 1'b0;
        w_addr_s      = {ADDR_W{1'b0}};
        w_data_s      = {WORD_W{1'b0}};
        is_repair_s   = 1'b0;
        repair_data_s = {BLOCK_SIZE{1'b0}};
        if (fill_gnt_s) begin
            w_en_s        = 1'b1;
            w_addr_s      = bus.fill_addr_i;
            is_repair_s   = 1'b1;
            repair_data_s = bus.fill_data_i;
        end else if (ld_gnt_s) begin
            r_en_s   = 1'b1;
            r_addr_s = bus.ld_addr_i;
        end else if (st_gnt_s) begin
            w_en_s   = 1'b1;
            w_addr_s = bus.st_addr_i;
            w_data_s = bus.st_data_i;
        end else begin
            r_en_s = 1'b0;
        end
    end

    // Starvation counter: grows while a store waits, saturates at the threshold, clears otherwise.
    always_comb begin
        starve_cnt_next_s = starve_cnt_r;
        if (bus.st_valid_i && !st_gnt_s) begin
            if (starve_cnt_r < STARVE_MAX_C) begin
                starve_cnt_next_s = starve_cnt_r + 4'd1;
            end else begin
                starve_cnt_next_s = starve_cnt_r;
            end
        end else begin
            starve_cnt_next_s = 4'd0;
        end
    end

    // Response stage capture: remember what was granted so the result can be tagged next cycle.
    always_comb begin
        resp_type_next_s = REQ_NONE;
        resp_addr_next_s = resp_addr_r;
        if (fill_gnt_s) begin
            resp_type_next_s = REQ_FILL;
        end else if (ld_gnt_s) begin
            resp_type_next_s = REQ_LD;
            resp_addr_next_s = bus.ld_addr_i;
        end else if (st_gnt_s) begin
            resp_type_next_s = REQ_ST;
            resp_addr_next_s = bus.st_addr_i;
        end else begin
            resp_type_next_s = REQ_NONE;
        end
    end

    // Miss FSM: enter MISS_WAIT on a missing response, leave on the MSHR handshake.
    always_comb begin
        state_next_s         = state_r;
        miss_addr_next_s     = miss_addr_r;
        miss_is_store_next_s = miss_is_store_r;
        case (state_r)
            IDLE: begin
                if (resp_miss_s) begin
                    state_next_s         = MISS_WAIT;
                    miss_addr_next_s     = resp_addr_r;
                    miss_is_store_next_s = resp_st_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MISS_WAIT: begin
                if (bus.miss_ready_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = MISS_WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, starvation, response and miss registers; reset drops any pending miss immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            starve_cnt_r    <= 4'd0;
            resp_type_r     <= REQ_NONE;
            resp_addr_r     <= {ADDR_W{1'b0}};
            miss_addr_r     <= {ADDR_W{1'b0}};
            miss_is_store_r <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            starve_cnt_r    <= starve_cnt_next_s;
            resp_type_r     <= resp_type_next_s;
            resp_addr_r     <= resp_addr_next_s;
            miss_addr_r     <= miss_addr_next_s;
            miss_is_store_r <= miss_is_store_next_s;
        end
    end

    assign bus.ld_ready_o          = ld_ready_s;
    assign bus.st_ready_o          = st_ready_s;
    assign bus.fill_ready_o        = 1'b1;
    assign bus.cache_r_en_o        = r_en_s;
    assign bus.cache_r_addr_o      = r_addr_s;
    assign bus.cache_w_en_o        = w_en_s;
    assign bus.cache_w_addr_o      = w_addr_s;
    assign bus.cache_w_data_o      = w_data_s;
    assign bus.cache_is_repair_o   = is_repair_s;
    assign bus.cache_repair_data_o = repair_data_s;
    assign bus.ld_resp_valid_o     = resp_ld_s;
    assign bus.ld_resp_hit_o       = resp_ld_s && bus.cache_r_hit_i;
    assign bus.ld_resp_data_o      = resp_ld_s ? bus.cache_r_data_i : {WORD_W{1'b0}};
    assign bus.st_resp_valid_o     = resp_st_s;
    assign bus.st_resp_hit_o       = resp_st_s && bus.cache_w_hit_i;
    assign bus.miss_valid_o        = (state_r == MISS_WAIT);
    assign bus.miss_addr_o         = miss_addr_r;
    assign bus.miss_is_store_o     = miss_is_store_r;

`ifdef DCACHE_ARB_PERF_EN
    dcache_perf_ctrs u_perf (
        .clk       (clk),
        .rst       (rst),
        .ld_gnt    (ld_gnt_s),
        .st_gnt    (st_gnt_s),
        .fill_gnt  (fill_gnt_s),
        .stall     (state_r == MISS_WAIT),
        .ld_cnt    (bus.perf_ld_cnt_o),
        .st_cnt    (bus.perf_st_cnt_o),
        .fill_cnt  (bus.perf_fill_cnt_o),
        .stall_cnt (bus.perf_stall_cnt_o)
    );
`else
    assign bus.perf_ld_cnt_o    = 32'd0;
    assign bus.perf_st_cnt_o    = 32'd0;
    assign bus.perf_fill_cnt_o  = 32'd0;
    assign bus.perf_stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_access_arbiter.sv
// Scoreboard bench for dcache_access_arbiter: a small cache model answers
// reads/writes one cycle after enable (address bit 9 set = miss), expected
// responses are queued at grant and checked when the DUT responds.
module tb_dcache_access_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

`ifdef DCACHE_ARB_PERF_EN
    localparam logic [31:0] EXP_STALL = 32'd4;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    dcache_access_arbiter_if bus ();

    dcache_access_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } ld_exp_t;

    ld_exp_t ld_q[$];
    logic    st_q[$];
    int      n_cmp = 0;
    int      n_err = 0;
    int      cyc = 0;
    int      ld_gnt_cyc = 0;
    int      ld_gnt_cyc_prev = 0;

    function automatic logic hit_fn(input logic [31:0] a);
        return !a[9];
    endfunction

    function automatic logic [31:0] data_fn(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cache model: result registered one cycle after the enable
    logic        m_r_hit;
    logic [31:0] m_r_data;
    logic        m_w_hit;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_r_hit  <= 1'b0;
            m_r_data <= 32'd0;
            m_w_hit  <= 1'b0;
        end else begin
            m_r_hit  <= bus.cache_r_en_o && hit_fn(bus.cache_r_addr_o);
            m_r_data <= bus.cache_r_en_o ? data_fn(bus.cache_r_addr_o) : 32'd0;
            m_w_hit  <= bus.cache_w_en_o && hit_fn(bus.cache_w_addr_o);
        end
    end
    assign bus.cache_r_hit_i  = m_r_hit;
    assign bus.cache_r_data_i = m_r_data;
    assign bus.cache_w_hit_i  = m_w_hit;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare responses against the queue, then push expectations for this cycle's grants
    always @(negedge clk) begin
        ld_exp_t e;
        logic    se;
        #2;
        if (!rst) begin
            if (bus.ld_resp_valid_o) begin
                if (ld_q.size() == 0) begin
                    check_eq("ld_resp_unexp", 128'(bus.ld_resp_valid_o), 128'd0);
                end else begin
                    e = ld_q.pop_front();
                    check_eq("ld_resp_hit", 128'(bus.ld_resp_hit_o), 128'(e.hit));
                    check_eq("ld_resp_data", 128'(bus.ld_resp_data_o), 128'(e.data));
                end
            end
            if (bus.st_resp_valid_o) begin
                if (st_q.size() == 0) begin
                    check_eq("st_resp_unexp", 128'(bus.st_resp_valid_o), 128'd0);
                end else begin
                    se = st_q.pop_front();
                    check_eq("st_resp_hit", 128'(bus.st_resp_hit_o), 128'(se));
                end
            end
            if (bus.ld_valid_i && bus.ld_ready_o) begin
                e.hit  = hit_fn(bus.ld_addr_i);
                e.data = data_fn(bus.ld_addr_i);
                ld_q.push_back(e);
                check_eq("ld_gnt_r_en", 128'(bus.cache_r_en_o), 128'd1);
                check_eq("ld_gnt_r_addr", 128'(bus.cache_r_addr_o), 128'(bus.ld_addr_i));
                ld_gnt_cyc_prev = ld_gnt_cyc;
                ld_gnt_cyc      = cyc;
            end
            if (bus.st_valid_i && bus.st_ready_o) begin
                st_q.push_back(hit_fn(bus.st_addr_i));
                check_eq("st_gnt_w_addr", 128'(bus.cache_w_addr_o), 128'(bus.st_addr_i));
                check_eq("st_gnt_w_data", 128'(bus.cache_w_data_o), 128'(bus.st_data_i));
            end
        end
    end

    // Call at a falling edge; returns at the falling edge after the grant with valid dropped
    task automatic issue_ld(input logic [31:0] a);
        int n = 0;
        bus.ld_valid_i = 1'b1;
        bus.ld_addr_i  = a;
        #1;
        while (!bus.ld_ready_o && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) check_eq("ld_grant_timeout", 128'(bus.ld_ready_o), 128'd1);
        @(negedge clk);
        bus.ld_valid_i = 1'b0;
    endtask

    task automatic issue_st(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        bus.st_valid_i = 1'b1;
        bus.st_addr_i  = a;
        bus.st_data_i  = d;
        #1;
        while (!bus.st_ready_o && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) check_eq("st_grant_timeout", 128'(bus.st_ready_o), 128'd1);
        @(negedge clk);
        bus.st_valid_i = 1'b0;
    endtask

    // Call at falling edge + 1; keeps pending requests valid until each is granted
    task automatic drain_reqs();
        logic lg;
        logic sg;
        for (int n = 0; n < 20 && (bus.ld_valid_i || bus.st_valid_i); n++) begin
            lg = bus.ld_valid_i && bus.ld_ready_o;
            sg = bus.st_valid_i && bus.st_ready_o;
            @(negedge clk);
            if (lg) bus.ld_valid_i = 1'b0;
            if (sg) bus.st_valid_i = 1'b0;
            #1;
        end
        check_eq("drain_done", 128'({bus.ld_valid_i, bus.st_valid_i}), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic stg;
        bus.ld_valid_i   = 1'b0;
        bus.ld_addr_i    = 32'd0;
        bus.st_valid_i   = 1'b0;
        bus.st_addr_i    = 32'd0;
        bus.st_data_i    = 32'd0;
        bus.fill_valid_i = 1'b0;
        bus.fill_addr_i  = 32'd0;
        bus.fill_data_i  = 128'd0;
        bus.miss_ready_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_miss_valid", 128'(bus.miss_valid_o), 128'd0);
        check_eq("rst_ld_resp_valid", 128'(bus.ld_resp_valid_o), 128'd0);
        check_eq("rst_st_resp_valid", 128'(bus.st_resp_valid_o), 128'd0);
        check_eq("rst_r_en", 128'(bus.cache_r_en_o), 128'd0);
        check_eq("rst_w_en", 128'(bus.cache_w_en_o), 128'd0);
        check_eq("rst_miss_addr", 128'(bus.miss_addr_o), 128'd0);
        check_eq("rst_perf_ld", 128'(bus.perf_ld_cnt_o), 128'd0);
        check_eq("rst_perf_stall", 128'(bus.perf_stall_cnt_o), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Back-to-back load hits
        issue_ld(32'h100);
        issue_ld(32'h104);
        repeat (2) @(negedge clk);
        check_eq("b2b_gap", 128'(ld_gnt_cyc - ld_gnt_cyc_prev), 128'd1);
        check_eq("b2b_ld_q_empty", 128'(ld_q.size()), 128'd0);

        // Load miss with MSHR stalling three cycles
        issue_ld(32'h200);
        bus.ld_valid_i = 1'b1;
        bus.ld_addr_i  = 32'h104;
        #1;
        check_eq("miss_det_ld_ready", 128'(bus.ld_ready_o), 128'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check_eq($sformatf("miss_valid_%0d", i), 128'(bus.miss_valid_o), 128'd1);
            check_eq($sformatf("miss_addr_%0d", i), 128'(bus.miss_addr_o), 128'h200);
            check_eq($sformatf("miss_is_st_%0d", i), 128'(bus.miss_is_store_o), 128'd0);
            check_eq($sformatf("miss_ld_ready_%0d", i), 128'(bus.ld_ready_o), 128'd0);
            if (i == 3) bus.miss_ready_i = 1'b1;
        end
        @(negedge clk);
        #1;
        check_eq("resume_miss_valid", 128'(bus.miss_valid_o), 128'd0);
        check_eq("resume_ld_ready", 128'(bus.ld_ready_o), 128'd1);
        check_eq("perf_stall", 128'(bus.perf_stall_cnt_o), 128'(EXP_STALL));
        bus.miss_ready_i = 1'b0;
        @(negedge clk);
        bus.ld_valid_i = 1'b0;
        repeat (2) @(negedge clk);

        // Store starvation: store wins on the 5th contended cycle
        bus.ld_valid_i = 1'b1;
        bus.ld_addr_i  = 32'h10C;
        bus.st_valid_i = 1'b1;
        bus.st_addr_i  = 32'h140;
        bus.st_data_i  = 32'h1234_5678;
        for (int i = 1; i <= 8; i++) begin
            #1;
            check_eq($sformatf("starve_st_rdy_%0d", i), 128'(bus.st_ready_o), 128'(i == 5));
            check_eq($sformatf("starve_ld_rdy_%0d", i), 128'(bus.ld_ready_o), 128'(i != 5));
            stg = bus.st_valid_i && bus.st_ready_o;
            @(negedge clk);
            if (stg) bus.st_valid_i = 1'b0;
        end
        bus.ld_valid_i = 1'b0;
        bus.st_valid_i = 1'b0;
        repeat (2) @(negedge clk);

        // Fill beats load and store
        bus.fill_valid_i = 1'b1;
        bus.fill_addr_i  = 32'h400;
        bus.fill_data_i  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        bus.ld_valid_i   = 1'b1;
        bus.ld_addr_i    = 32'h110;
        bus.st_valid_i   = 1'b1;
        bus.st_addr_i    = 32'h144;
        bus.st_data_i    = 32'hCAFE_F00D;
        #1;
        check_eq("fill_w_en", 128'(bus.cache_w_en_o), 128'd1);
        check_eq("fill_repair", 128'(bus.cache_is_repair_o), 128'd1);
        check_eq("fill_w_addr", 128'(bus.cache_w_addr_o), 128'h400);
        check_eq("fill_data", bus.cache_repair_data_o, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        check_eq("fill_ld_ready", 128'(bus.ld_ready_o), 128'd0);
        check_eq("fill_st_ready", 128'(bus.st_ready_o), 128'd0);
        check_eq("fill_r_en", 128'(bus.cache_r_en_o), 128'd0);
        @(negedge clk);
        bus.fill_valid_i = 1'b0;
        #1;
        drain_reqs();
        repeat (2) @(negedge clk);

        // Store miss, then a fill during MISS_WAIT
        issue_st(32'h300, 32'hBEEF_0001);
        @(negedge clk);
        #1;
        check_eq("stmiss_valid", 128'(bus.miss_valid_o), 128'd1);
        check_eq("stmiss_addr", 128'(bus.miss_addr_o), 128'h300);
        check_eq("stmiss_is_st", 128'(bus.miss_is_store_o), 128'd1);
        bus.fill_valid_i = 1'b1;
        bus.fill_addr_i  = 32'h500;
        bus.fill_data_i  = 128'hAAAA_5555;
        #1;
        check_eq("mw_fill_ready", 128'(bus.fill_ready_o), 128'd1);
        check_eq("mw_fill_w_en", 128'(bus.cache_w_en_o), 128'd1);
        check_eq("mw_fill_repair", 128'(bus.cache_is_repair_o), 128'd1);
        check_eq("mw_fill_w_addr", 128'(bus.cache_w_addr_o), 128'h500);
        @(negedge clk);
        bus.fill_valid_i = 1'b0;
        #1;
        check_eq("mw_after_fill_valid", 128'(bus.miss_valid_o), 128'd1);
        check_eq("mw_after_fill_addr", 128'(bus.miss_addr_o), 128'h300);
        check_eq("mw_after_fill_is_st", 128'(bus.miss_is_store_o), 128'd1);
        bus.miss_ready_i = 1'b1;
        @(negedge clk);
        bus.miss_ready_i = 1'b0;
        #1;
        check_eq("stmiss_released", 128'(bus.miss_valid_o), 128'd0);
        repeat (2) @(negedge clk);

        // Reset pulsed during MISS_WAIT
        issue_ld(32'h220);
        @(negedge clk);
        #1;
        check_eq("rmiss_valid", 128'(bus.miss_valid_o), 128'd1);
        check_eq("rmiss_addr", 128'(bus.miss_addr_o), 128'h220);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rmid_miss_valid", 128'(bus.miss_valid_o), 128'd0);
        check_eq("rmid_miss_addr", 128'(bus.miss_addr_o), 128'd0);
        check_eq("rmid_ld_resp", 128'(bus.ld_resp_valid_o), 128'd0);
        check_eq("rmid_st_resp", 128'(bus.st_resp_valid_o), 128'd0);
        check_eq("rmid_r_en", 128'(bus.cache_r_en_o), 128'd0);
        check_eq("rmid_perf_stall", 128'(bus.perf_stall_cnt_o), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue_ld(32'h108);
        repeat (3) @(negedge clk);

        check_eq("final_ld_q_empty", 128'(ld_q.size()), 128'd0);
        check_eq("final_st_q_empty", 128'(st_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
